// File: rtl/mmio_console_timer.sv
// Memory-mapped console UART (8-entry TX FIFO, 8N1 serializer), free-running cycle counter
// and compare register driving a level timer interrupt, answering with RAM-like timing.
module mmio_console_timer #(
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [3:0]            wenableL,
   input  logic [3:0][7:0]       data_w,
   output logic [3:0][7:0]       data_r,
   output logic                  uart_tx,
   output logic                  timer_irq
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   clk_cnt_q, clk_cnt_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;

   logic [7:0]        fifo_mem [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]     count_q, count_d;
   logic              ovf_q, ovf_d;

   logic [31:0]       cycle_q, cycle_d;
   logic [31:0]       cmp_q, cmp_d;
   logic              irq_q;

   logic              sel_tx, sel_status, sel_cycle, sel_cmp;
   logic              fifo_empty, fifo_full, pop, push_req, push, bit_done;
   logic [31:0]       status;
   logic              unused_addr;

   assign unused_addr = ^{addr[1:0], addr[ADDR_WIDTH-1:4]};

   function automatic logic [31:0] merge_lanes(input logic [31:0]      old,
                                               input logic [3:0][7:0] wdata,
                                               input logic [3:0]      wen_n);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (!wen_n[i]) r[i*8 +: 8] = wdata[i];
      end
      return r;
   endfunction

   assign sel_tx     = addr[3:2] == 2'd0;
   assign sel_status = addr[3:2] == 2'd1;
   assign sel_cycle  = addr[3:2] == 2'd2;
   assign sel_cmp    = addr[3:2] == 2'd3;

   assign fifo_empty = count_q == '0;
   assign fifo_full  = count_q == (PtrW + 1)'(FIFO_DEPTH);
   assign pop        = (state_q == StIdle) && !fifo_empty;
   assign push_req   = sel_tx && !wenableL[0];
   // A full FIFO still accepts when the serializer frees a slot on the same edge.
   assign push       = push_req && (!fifo_full || pop);

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + (PtrW + 1)'(1);
      else if (!push && pop) count_d = count_q - (PtrW + 1)'(1);

      ovf_d = ovf_q;
      if (push_req && !push)                               ovf_d = 1'b1;
      else if (sel_status && !wenableL[0] && data_w[0][3]) ovf_d = 1'b0;

      cycle_d = (sel_cycle && wenableL != 4'hF) ? merge_lanes(cycle_q, data_w, wenableL)
                                                : cycle_q + 32'd1;
      cmp_d   = sel_cmp ? merge_lanes(cmp_q, data_w, wenableL) : cmp_q;
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= data_w[0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         cycle_q  <= '0;
         cmp_q    <= 32'hFFFF_FFFF;
         irq_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_d;
         ovf_q   <= ovf_d;
         cycle_q <= cycle_d;
         cmp_q   <= cmp_d;
         irq_q   <= cycle_q >= cmp_q;
      end
   end

   assign bit_done = clk_cnt_q == CntW'(CLKS_PER_BIT - 1);

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (pop) begin
               state_d   = StStart;
               shift_d   = fifo_mem[rd_ptr_q];
               clk_cnt_d = '0;
               tx_d      = 1'b0;
            end
         end
         StStart: begin
            if (bit_done) begin
               state_d   = StData;
               clk_cnt_d = '0;
               bit_cnt_d = '0;
               tx_d      = shift_q[0];
            end else begin
               clk_cnt_d = clk_cnt_q + CntW'(1);
            end
         end
         StData: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               if (bit_cnt_q == 3'd7) begin
                  state_d = StStop;
                  tx_d    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CntW'(1);
            end
         end
         StStop: begin
            if (bit_done) begin
               state_d = StIdle;
               tx_d    = 1'b1;
            end else begin
               clk_cnt_d = clk_cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
      end
   end

   assign status = {20'd0, 4'(count_q), 4'd0, ovf_q, state_q != StIdle, fifo_full, fifo_empty};

   always_comb begin
      data_r = '0;
      unique case (addr[3:2])
         2'd0:    data_r = '0;
         2'd1:    data_r = status;
         2'd2:    data_r = cycle_q;
         default: data_r = cmp_q;
      endcase
   end

   assign uart_tx   = tx_q;
   assign timer_irq = irq_q;

endmodule
